// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: registers an opcode, decodes it and drives ALU op/flags for EXEC_CYCLES cycles.
// Latency: opcode accepted at edge N, ctrl_valid rises on edge N+1 and stays high for EXEC_CYCLES cycles; issue interval EXEC_CYCLES+2.
// Backpressure: op_ready is high only in IDLE; HALT and FAULT hold it low until reset.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   op_valid, op          opcode offered by the fetch side
//   op_ready              sequencer can take an opcode this cycle
//   alu_op, flags         registered ALU operation and datapath flags (flags[0] is the first encoding bit)
//   ctrl_valid            alu_op/flags are to be acted on this cycle
//   halted, error         sticky status: halt executed / invalid opcode seen
//   instr_count           retired instruction count, wraps silently
// The fixed flag encodings are 6 bits wide, so FLAGS_W must be at least 6; any extra bits read 0.

module control_sequencer #(
    parameter int OP_W        = 4,
    parameter int ALU_OP_W    = 2,
    parameter int FLAGS_W     = 6,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [OP_W-1:0]     op,
    output logic                op_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [0:FLAGS_W-1]  flags,
    output logic                ctrl_valid,
    output logic                halted,
    output logic                error,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        HALT   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // The exec counter runs 0..EXEC_CYCLES-1; keep it at least one bit wide.
    localparam int              EC_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(EXEC_CYCLES - 1);

    // First opcode value that has no meaning.
    localparam logic [OP_W-1:0] OP_FIRST_BAD = OP_W'(12);
    localparam logic [OP_W-1:0] OP_FIRST_ALU = OP_W'(4);

    state_t                state_q,     state_d;
    logic [OP_W-1:0]       op_reg,      op_reg_d;
    logic [EC_W-1:0]       exec_cnt,    exec_cnt_d;
    logic [ALU_OP_W-1:0]   alu_op_d;
    logic [0:FLAGS_W-1]    flags_d;
    logic                  ctrl_valid_d;
    logic                  halted_d;
    logic                  error_d;
    logic [CNT_W-1:0]      instr_count_d;
    logic [5:0]            enc;

    // Ready is a pure function of the registered state, so it is high in the
    // first cycle after reset releases.
    assign op_ready = (state_q == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_reg      <= '0;
            exec_cnt    <= '0;
            alu_op      <= '0;
            flags       <= '0;
            ctrl_valid  <= 1'b0;
            halted      <= 1'b0;
            error       <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q     <= state_d;
            op_reg      <= op_reg_d;
            exec_cnt    <= exec_cnt_d;
            alu_op      <= alu_op_d;
            flags       <= flags_d;
            ctrl_valid  <= ctrl_valid_d;
            halted      <= halted_d;
            error       <= error_d;
            instr_count <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_reg_d      = op_reg;
        exec_cnt_d    = exec_cnt;
        alu_op_d      = alu_op;
        flags_d       = flags;
        ctrl_valid_d  = ctrl_valid;
        halted_d      = halted;
        error_d       = error;
        instr_count_d = instr_count;
        enc           = 6'b000000;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_reg_d = op;
                    state_d  = DECODE;
                end
            end

            DECODE: begin
                if (op_reg == '0) begin
                    // Halt retires immediately; it never produces a control pulse.
                    state_d       = HALT;
                    halted_d      = 1'b1;
                    instr_count_d = instr_count + CNT_W'(1);
                end else if (op_reg >= OP_FIRST_BAD) begin
                    state_d = FAULT;
                    error_d = 1'b1;
                    flags_d = '0;
                end else begin
                    case (op_reg)
                        OP_W'(2):                               enc = 6'b010100;
                        OP_W'(3):                               enc = 6'b100110;
                        OP_W'(4), OP_W'(6), OP_W'(8), OP_W'(10): enc = 6'b111111;
                        OP_W'(5), OP_W'(7), OP_W'(9), OP_W'(11): enc = 6'b110110;
                        default:                                enc = 6'b000000;
                    endcase
                    flags_d      = '0;
                    // enc[5] lands in flags[0]: the leftmost encoding bit is flag 0.
                    flags_d[0:5] = enc;
                    // ALU opcodes come in reg/imm pairs starting at 4, so
                    // (op-4)/2 gives add, sub, and, or. Other ops keep alu_op.
                    if (op_reg >= OP_FIRST_ALU) begin
                        alu_op_d = ALU_OP_W'((op_reg - OP_FIRST_ALU) >> 1);
                    end
                    state_d      = EXEC;
                    ctrl_valid_d = 1'b1;
                    exec_cnt_d   = '0;
                end
            end

            EXEC: begin
                if (exec_cnt == EC_LAST) begin
                    state_d       = IDLE;
                    ctrl_valid_d  = 1'b0;
                    exec_cnt_d    = '0;
                    instr_count_d = instr_count + CNT_W'(1);
                end else begin
                    exec_cnt_d = exec_cnt + EC_W'(1);
                end
            end

            // Terminal until reset; op_valid is ignored.
            HALT:  state_d = HALT;
            FAULT: state_d = FAULT;

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: two instances (fast EXEC_CYCLES=1 with 3-bit counter,
// and EXEC_CYCLES=3 with FLAGS_W=8), inputs driven and outputs sampled on the falling edge.
// Expected values are hand-derived from the opcode table.

module tb_control_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: EXEC_CYCLES=1, CNT_W=3
    logic        ra, va, rdya, cva, hla, era;
    logic [3:0]  opa;
    logic [1:0]  alua;
    logic [0:5]  flga;
    logic [2:0]  cnta;

    // Instance B: EXEC_CYCLES=3, FLAGS_W=8
    logic        rb, vb, rdyb, cvb, hlb, erb;
    logic [3:0]  opb;
    logic [1:0]  alub;
    logic [0:7]  flgb;
    logic [15:0] cntb;

    int errors = 0;
    int checks = 0;

    control_sequencer #(.OP_W(4), .ALU_OP_W(2), .FLAGS_W(6), .EXEC_CYCLES(1), .CNT_W(3)) dut_a (
        .clock(clock), .reset(ra), .op_valid(va), .op(opa), .op_ready(rdya),
        .alu_op(alua), .flags(flga), .ctrl_valid(cva), .halted(hla), .error(era),
        .instr_count(cnta)
    );

    control_sequencer #(.OP_W(4), .ALU_OP_W(2), .FLAGS_W(8), .EXEC_CYCLES(3), .CNT_W(16)) dut_b (
        .clock(clock), .reset(rb), .op_valid(vb), .op(opb), .op_ready(rdyb),
        .alu_op(alub), .flags(flgb), .ctrl_valid(cvb), .halted(hlb), .error(erb),
        .instr_count(cntb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge. Waits (bounded) for ready, issues one
    // opcode and follows it through DECODE, the single EXEC cycle and back to IDLE.
    task automatic run_a(input logic [3:0] o, input logic [5:0] ef, input logic [1:0] ea, input string tag);
        int n = 0;
        while (!rdya && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, rdya, 1);
        va  = 1'b1;
        opa = o;
        @(negedge clock);
        va = 1'b0;
        chk({tag, "_dec_rdy"}, rdya, 0);
        chk({tag, "_dec_cv"},  cva,  0);
        @(negedge clock);
        chk({tag, "_cv"},    cva,  1);
        chk({tag, "_flags"}, flga, ef);
        chk({tag, "_alu"},   alua, ea);
        @(negedge clock);
        chk({tag, "_cv_end"},  cva,  0);
        chk({tag, "_rdy_end"}, rdya, 1);
    endtask

    logic [3:0] b2b_op  [5] = '{4'd2, 4'd3, 4'd4, 4'd7, 4'd1};
    logic [5:0] b2b_fl  [5] = '{6'b010100, 6'b100110, 6'b111111, 6'b110110, 6'b000000};
    logic [1:0] b2b_alu [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};

    logic seen_cv, seen_rdy;

    initial begin
        ra = 1'b1; rb = 1'b1; va = 1'b0; vb = 1'b0; opa = '0; opb = '0;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_cv",    cva,  0);
        chk("rst_flags", flga, 0);
        chk("rst_alu",   alua, 0);
        chk("rst_halt",  hla,  0);
        chk("rst_err",   era,  0);
        chk("rst_cnt",   cnta, 0);
        ra = 1'b0; rb = 1'b0;
        @(negedge clock);
        chk("rst_rdy", rdya, 1);

        // Back-to-back stream with op_valid held high: one accept every 3 cycles
        va = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_accept_rdy", rdya, 1);
            opa = b2b_op[i];
            @(negedge clock);
            chk("b2b_dec_rdy", rdya, 0);
            opa = 4'd13;                        // ignored while not ready
            @(negedge clock);
            chk("b2b_cv",    cva,  1);
            chk("b2b_flags", flga, b2b_fl[i]);
            chk("b2b_alu",   alua, b2b_alu[i]);
            @(negedge clock);
        end
        va = 1'b0;
        chk("b2b_cv_end", cva,  0);
        chk("b2b_cnt",    cnta, 5);
        chk("b2b_err",    era,  0);

        // Logic ops
        run_a(4'd8,  6'b111111, 2'd2, "andr");
        run_a(4'd11, 6'b110110, 2'd3, "orv");
        chk("logic_cnt", cnta, 7);

        // Halt after ADDV
        ra = 1'b1; @(negedge clock); ra = 1'b0;
        chk("halt_rst_cnt", cnta, 0);
        run_a(4'd5, 6'b110110, 2'd0, "addv");
        chk("addv_cnt", cnta, 1);
        va = 1'b1; opa = 4'd0;
        @(negedge clock);
        chk("halt_dec_halted", hla, 0);
        opa = 4'd4;
        @(negedge clock);
        chk("halt_halted", hla,  1);
        chk("halt_cnt",    cnta, 2);
        chk("halt_rdy",    rdya, 0);
        seen_cv = 1'b0; seen_rdy = 1'b0;
        repeat (6) begin
            @(negedge clock);
            seen_cv  |= cva;
            seen_rdy |= rdya;
        end
        va = 1'b0;
        chk("halt_no_cv",    seen_cv,  0);
        chk("halt_no_rdy",   seen_rdy, 0);
        chk("halt_cnt_hold", cnta,     2);
        chk("halt_sticky",   hla,      1);

        // Invalid opcode after COPY: flags cleared, count unchanged
        ra = 1'b1; @(negedge clock); ra = 1'b0;
        chk("inv_rst_halted", hla, 0);
        run_a(4'd3, 6'b100110, 2'd0, "copy");
        va = 1'b1; opa = 4'd13;
        @(negedge clock);
        chk("inv_dec_err", era, 0);
        opa = 4'd2;
        @(negedge clock);
        chk("inv_err",   era,  1);
        chk("inv_flags", flga, 0);
        chk("inv_cv",    cva,  0);
        chk("inv_rdy",   rdya, 0);
        chk("inv_cnt",   cnta, 1);
        seen_cv = 1'b0; seen_rdy = 1'b0;
        repeat (6) begin
            @(negedge clock);
            seen_cv  |= cva;
            seen_rdy |= rdya;
        end
        va = 1'b0;
        chk("inv_no_cv",    seen_cv,  0);
        chk("inv_no_rdy",   seen_rdy, 0);
        chk("inv_sticky",   era,      1);
        chk("inv_cnt_hold", cnta,     1);

        // Counter wrap: 9 nops on a 3-bit counter
        ra = 1'b1; @(negedge clock); ra = 1'b0;
        chk("wrap_rst_err", era, 0);
        for (int i = 0; i < 9; i++) begin
            run_a(4'd1, 6'b000000, 2'd0, "nop");
            chk("wrap_cnt", cnta, (i + 1) % 8);
        end

        // Instance B: SUBR held for three cycles, 8-bit flags with zero upper bits
        chk("b_rdy", rdyb, 1);
        vb = 1'b1; opb = 4'd6;
        @(negedge clock);
        vb = 1'b0;
        chk("b_dec_cv", cvb, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("b_subr_cv",    cvb,  1);
            chk("b_subr_flags", flgb, 8'b11111100);
            chk("b_subr_alu",   alub, 1);
            chk("b_subr_rdy",   rdyb, 0);
        end
        @(negedge clock);
        chk("b_subr_cv_end", cvb,  0);
        chk("b_subr_rdy_end", rdyb, 1);
        chk("b_subr_cnt",    cntb, 1);

        // Instance B: ADDR interrupted by reset in its second EXEC cycle
        vb = 1'b1; opb = 4'd4;
        @(negedge clock);
        vb = 1'b0;
        @(negedge clock);
        chk("b_addr_cv",  cvb,  1);
        chk("b_addr_alu", alub, 0);
        @(negedge clock);
        chk("b_addr_cv2", cvb, 1);
        rb = 1'b1;
        #1;
        chk("b_arst_cv",    cvb,  0);
        chk("b_arst_flags", flgb, 0);
        chk("b_arst_alu",   alub, 0);
        chk("b_arst_cnt",   cntb, 0);
        chk("b_arst_halt",  hlb,  0);
        chk("b_arst_err",   erb,  0);
        @(negedge clock);
        rb = 1'b0;
        @(negedge clock);
        chk("b_post_rdy", rdyb, 1);
        chk("b_post_cv",  cvb,  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
